// File: rtl/vga_pkg.sv
// 640x480@60 timing constants shared by the VGA timing generator and the sync receiver.
package vga_pkg;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BACK   = 48;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FRONT  = 16;
  localparam int VGA_H_TOTAL  = VGA_H_SYNC + VGA_H_BACK + VGA_H_ACTIVE + VGA_H_FRONT;
  localparam int VGA_H_START  = VGA_H_SYNC + VGA_H_BACK;

  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BACK   = 33;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FRONT  = 10;
  localparam int VGA_V_TOTAL  = VGA_V_SYNC + VGA_V_BACK + VGA_V_ACTIVE + VGA_V_FRONT;
  localparam int VGA_V_START  = VGA_V_SYNC + VGA_V_BACK;

  localparam int VGA_RGB_W    = 12;
endpackage

// File: rtl/vga_sync_edge.sv
// One-sample history of a sync line with a combinational leading-edge output
// (current sample active, previous sample inactive).
module vga_sync_edge #(
  parameter bit SYNC_POL = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic sync,
  output logic le
);
  logic prev;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) prev <= ~SYNC_POL;
    else       prev <= sync;
  end

  assign le = (sync == SYNC_POL) && (prev != SYNC_POL);
endmodule

// File: rtl/vga_sync_rx.sv
// VGA sync receiver: recovers pixel coordinates, data-enable and frame start from
// hs/vs/rgb, measures line/frame lengths and reports lock to nominal timing.
module vga_sync_rx import vga_pkg::*; #(
  parameter int H_TOTAL     = VGA_H_TOTAL,
  parameter int H_START     = VGA_H_START,
  parameter int H_ACTIVE    = VGA_H_ACTIVE,
  parameter int V_TOTAL     = VGA_V_TOTAL,
  parameter int V_START     = VGA_V_START,
  parameter int V_ACTIVE    = VGA_V_ACTIVE,
  parameter bit SYNC_POL    = 1'b0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 hs,
  input  logic                 vs,
  input  logic [VGA_RGB_W-1:0] rgb,
  output logic [9:0]           pix_x,
  output logic [9:0]           pix_y,
  output logic                 de,
  output logic [VGA_RGB_W-1:0] rgb_out,
  output logic                 frame_start,
  output logic                 locked,
  output logic [10:0]          h_len,
  output logic [9:0]           v_len
);
  localparam logic [10:0] H_SAT = 11'h7FF;
  localparam logic [9:0]  V_SAT = 10'h3FF;

  logic        hs_le, vs_le;
  logic [10:0] hcnt_q, hcnt_cur;
  logic [9:0]  vcnt_q, vcnt_cur;
  logic        vs_pend_q, line_err_q;
  logic [2:0]  lock_cnt_q, lock_cnt_nxt;
  logic [11:0] h_meas;
  logic [10:0] v_meas;
  logic        frame_bnd, line_bad, frame_good, loss, win, locked_nxt;

  vga_sync_edge #(.SYNC_POL(SYNC_POL)) u_hs_edge (
    .clk(clk), .rstn(rstn), .sync(hs), .le(hs_le)
  );
  vga_sync_edge #(.SYNC_POL(SYNC_POL)) u_vs_edge (
    .clk(clk), .rstn(rstn), .sync(vs), .le(vs_le)
  );

  // hcnt_cur/vcnt_cur are the coordinates of the sample on the inputs right now.
  always_comb begin
    h_meas    = {1'b0, hcnt_q} + 12'd1;
    v_meas    = {1'b0, vcnt_q} + 11'd1;
    frame_bnd = hs_le & (vs_pend_q | vs_le);
    line_bad  = hs_le & (h_meas != 12'(H_TOTAL));

    hcnt_cur = (hcnt_q == H_SAT) ? hcnt_q : hcnt_q + 11'd1;
    if (hs_le) hcnt_cur = '0;

    vcnt_cur = vcnt_q;
    if (frame_bnd)  vcnt_cur = '0;
    else if (hs_le) vcnt_cur = (vcnt_q == V_SAT) ? vcnt_q : vcnt_q + 10'd1;

    // The first boundary after reset always sees vcnt_q saturated, so it is bad.
    frame_good   = (v_meas == 11'(V_TOTAL)) & ~(line_err_q | line_bad);
    lock_cnt_nxt = lock_cnt_q;
    if (frame_bnd) begin
      if (!frame_good)                          lock_cnt_nxt = '0;
      else if (lock_cnt_q != 3'(LOCK_FRAMES))   lock_cnt_nxt = lock_cnt_q + 3'd1;
    end
    loss = (hcnt_cur == H_SAT) | (vcnt_cur == V_SAT);
    if (loss) lock_cnt_nxt = '0;
    locked_nxt = (lock_cnt_nxt == 3'(LOCK_FRAMES));

    win = (hcnt_cur >= 11'(H_START)) && (hcnt_cur < 11'(H_START + H_ACTIVE)) &&
          (vcnt_cur >= 10'(V_START)) && (vcnt_cur < 10'(V_START + V_ACTIVE));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hcnt_q      <= H_SAT;
      vcnt_q      <= V_SAT;
      vs_pend_q   <= 1'b0;
      line_err_q  <= 1'b0;
      lock_cnt_q  <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      de          <= 1'b0;
      rgb_out     <= '0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      h_len       <= '0;
      v_len       <= '0;
    end else begin
      hcnt_q     <= hcnt_cur;
      vcnt_q     <= vcnt_cur;
      lock_cnt_q <= lock_cnt_nxt;
      locked     <= locked_nxt;

      if (frame_bnd)  vs_pend_q <= 1'b0;
      else if (vs_le) vs_pend_q <= 1'b1;

      if (frame_bnd)     line_err_q <= 1'b0;
      else if (line_bad) line_err_q <= 1'b1;

      // A saturated count means no previous edge, so there is no length to report.
      if (hs_le && (hcnt_q != H_SAT)) h_len <= h_meas[10:0];
      if (frame_bnd)                  v_len <= v_meas[9:0];

      de          <= win & locked_nxt;
      frame_start <= frame_bnd;
      if (win && locked_nxt) begin
        pix_x   <= 10'(hcnt_cur - 11'(H_START));
        pix_y   <= 10'({1'b0, vcnt_cur} - 11'(V_START));
        rgb_out <= rgb;
      end else begin
        pix_x   <= '0;
        pix_y   <= '0;
        rgb_out <= '0;
      end
    end
  end
endmodule

// File: tb/tb_vga_sync_rx.sv
// Directed bench for vga_sync_rx using a reduced 20x12 timing so whole frames stay short.
module tb_vga_sync_rx;
  localparam int HT = 20, HST = 5, HA = 10, HSW = 3;
  localparam int VT = 12, VST = 3, VA = 6,  VSW = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        hs = 1'b1;
  logic        vs = 1'b1;
  logic [11:0] rgb = '0;
  logic [9:0]  pix_x, pix_y, v_len;
  logic        de, frame_start, locked;
  logic [11:0] rgb_out;
  logic [10:0] h_len;

  int n_checks = 0;
  int n_fail   = 0;

  vga_sync_rx #(
    .H_TOTAL(HT), .H_START(HST), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_START(VST), .V_ACTIVE(VA),
    .SYNC_POL(1'b0), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .rstn(rstn), .hs(hs), .vs(vs), .rgb(rgb),
    .pix_x(pix_x), .pix_y(pix_y), .de(de), .rgb_out(rgb_out),
    .frame_start(frame_start), .locked(locked), .h_len(h_len), .v_len(v_len)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pix_x"}, 32'(pix_x), 0);
    chk({tag, "_pix_y"}, 32'(pix_y), 0);
    chk({tag, "_de"}, 32'(de), 0);
    chk({tag, "_rgb_out"}, 32'(rgb_out), 0);
    chk({tag, "_frame_start"}, 32'(frame_start), 0);
    chk({tag, "_locked"}, 32'(locked), 0);
    chk({tag, "_h_len"}, 32'(h_len), 0);
    chk({tag, "_v_len"}, 32'(v_len), 0);
  endtask

  // Drive one sample; on return the outputs belonging to that sample are visible.
  task automatic step(input logic h, input logic v, input logic [11:0] c);
    @(negedge clk);
    hs = h; vs = v; rgb = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic exp_lock);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b1, 12'h3C3);
      chk("idle_de", 32'(de), 0);
      chk("idle_pix_x", 32'(pix_x), 0);
      chk("idle_pix_y", 32'(pix_y), 0);
      chk("idle_rgb_out", 32'(rgb_out), 0);
      chk("idle_locked", 32'(locked), 32'(exp_lock));
    end
  endtask

  function automatic logic [11:0] color(input int gx, input int gy);
    int x;
    x = gx - HST;
    if (gx < HST || gx >= HST + HA || gy < VST || gy >= VST + VA) return 12'h3C3;
    if (x < 3) return 12'hF00;
    if (x > 7) return 12'hFFF;
    return {4'(x), 4'(gy), 4'h5};
  endfunction

  // bad: line index sent one sample short; early: raise vs mid-line on the last line.
  task automatic frame(input int bad, input logic early, input logic exp_lock,
                       input int exp_vlen, input int n_lines);
    int fs_cnt, de_cnt, len;
    logic h, v, w;
    logic [11:0] c;
    fs_cnt = 0;
    de_cnt = 0;
    for (int gy = 0; gy < n_lines; gy++) begin
      len = (gy == bad) ? HT - 1 : HT;
      for (int gx = 0; gx < len; gx++) begin
        h = !(gx < HSW);
        v = !((gy < VSW) || (early && gy == VT - 1 && gx >= 10));
        c = color(gx, gy);
        step(h, v, c);
        w = exp_lock && gx >= HST && gx < HST + HA && gy >= VST && gy < VST + VA;
        chk("de", 32'(de), 32'(w));
        chk("pix_x", 32'(pix_x), w ? gx - HST : 0);
        chk("pix_y", 32'(pix_y), w ? gy - VST : 0);
        chk("rgb_out", 32'(rgb_out), w ? 32'(c) : 0);
        chk("locked", 32'(locked), 32'(exp_lock));
        if (frame_start) fs_cnt++;
        if (de) de_cnt++;
        if (gx == 0 && gy > 0) chk("h_len", 32'(h_len), (gy - 1 == bad) ? HT - 1 : HT);
        if (gx == 0 && gy == 0) begin
          chk("frame_start", 32'(frame_start), 1);
          if (exp_vlen >= 0) chk("v_len", 32'(v_len), exp_vlen);
        end
      end
    end
    if (n_lines == VT) begin
      chk("frame_start_count", fs_cnt, 1);
      chk("de_count", de_cnt, exp_lock ? HA * VA : 0);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("por");
    @(negedge clk);
    rstn = 1'b1;
    idle(30, 1'b0);

    frame(-1, 1'b0, 1'b0, -1, VT);
    frame(-1, 1'b0, 1'b0, VT, VT);
    frame(-1, 1'b0, 1'b1, VT, VT);
    frame(4,  1'b0, 1'b1, VT, VT);
    frame(-1, 1'b0, 1'b0, VT, VT);
    frame(-1, 1'b0, 1'b0, VT, VT);
    frame(-1, 1'b1, 1'b1, VT, VT);
    frame(-1, 1'b0, 1'b1, VT, VT);

    // Last frame sample left hcnt at 19; sample k of the idle run has hcnt 19+k.
    for (int k = 1; k <= 2027; k++) begin
      step(1'b1, 1'b1, 12'h3C3);
      chk("sat_de", 32'(de), 0);
      chk("sat_locked_hold", 32'(locked), 1);
    end
    step(1'b1, 1'b1, 12'h3C3);
    chk("sat_locked_drop", 32'(locked), 0);
    chk("sat_de_drop", 32'(de), 0);

    frame(-1, 1'b0, 1'b0, -1, 5);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    idle(30, 1'b0);
    frame(-1, 1'b0, 1'b0, -1, VT);
    frame(-1, 1'b0, 1'b0, VT, VT);
    frame(-1, 1'b0, 1'b1, VT, VT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_sync_rx.md
Name: vga_sync_rx

Overview:
- Receiver end of the 640x480@60 VGA interface driven by vga_ctrl: consumes hs, vs and 12-bit RGB sampled on the pixel clock.
- Recovers the pixel coordinates, the data-enable and the frame start from the incoming stream.
- Measures line and frame lengths and asserts locked once timing matches nominal for LOCK_FRAMES consecutive frames.
- Used as a loopback checker and capture front-end; it is the inverse of the timing generator.

Parameters:
- H_TOTAL, 800, pixels per line
- H_START, 144, first active pixel, counted from the hs leading edge (sync 96 + back porch 48)
- H_ACTIVE, 640, active pixels per line
- V_TOTAL, 525, lines per frame
- V_START, 35, first active line, counted from the vs line (sync 2 + back porch 33)
- V_ACTIVE, 480, active lines per frame
- SYNC_POL, 0, active level of hs/vs (0 = active-low)
- LOCK_FRAMES, 2, consecutive good frames required before lock, range 1..7

Ports:
- clk  in  1  pixel clock (25 MHz vga_clk)
- rstn  in  1  asynchronous active-low reset
- hs  in  1  horizontal sync
- vs  in  1  vertical sync
- rgb  in  12  pixel data {R[3:0],G[3:0],B[3:0]}
- pix_x  out  10  active-area column, valid when de
- pix_y  out  10  active-area row, valid when de
- de  out  1  active pixel strobe
- rgb_out  out  12  rgb delayed to align with de
- frame_start  out  1  one-cycle pulse on the first sample of line 0
- locked  out  1  timing matches nominal
- h_len  out  11  last measured line length in samples
- v_len  out  10  last measured frame length in lines

Behaviour:
- Reset (async, rstn=0): every output is 0. Internal hcnt=2047, vcnt=1023, hs/vs history registers are set to the inactive level, vs_pend=0, lock_cnt=0, line_err=0.
- Leading edge (LE): the current sample is at the active level (== SYNC_POL) and the previous sample was not. Detection uses a 1-sample history register and no extra latency.
- hcnt, 11 bits:
  - On an hs LE the sample gets hcnt=0; otherwise hcnt+1, saturating at 2047.
- Line measurement on each hs LE:
  - h_len <= previous hcnt+1, unless the previous hcnt is at saturation 2047, in which case no update.
  - If previous hcnt+1 != H_TOTAL, set line_err.
- vs handling:
  - A vs LE sets vs_pend.
  - At an hs LE with vs_pend set, or with vs LE in the same sample, vcnt=0 and vs_pend is cleared.
  - At any other hs LE, vcnt+1, saturating at 1023.
- Frame boundary (vcnt reset to 0):
  - v_len <= previous vcnt+1.
  - The frame is good iff previous vcnt+1 == V_TOTAL and line_err==0, where line_err includes the check made at this same hs LE.
  - Good frame: lock_cnt increments, saturating at LOCK_FRAMES. Bad frame: lock_cnt=0.
  - line_err is cleared.
  - The first boundary after reset is always treated as bad, because the partial frame is unknown.
- locked = (lock_cnt == LOCK_FRAMES), registered.
- Loss of signal: hcnt reaching 2047 or vcnt reaching 1023 forces lock_cnt=0 and locked=0 on the next cycle.
- Outputs are registered with 1-cycle latency after the input sample:
  - win = (H_START <= hcnt < H_START+H_ACTIVE) and (V_START <= vcnt < V_START+V_ACTIVE).
  - de = win & locked.
  - pix_x = hcnt-H_START and pix_y = vcnt-V_START when de, else 0.
  - rgb_out = rgb when de, else 0.
  - frame_start = 1 for the sample at hcnt=0, vcnt=0, and is independent of locked.
- Width rules: subtractions are computed at 11 bits and truncated to 10; within the window they never underflow.
- Reset asserted mid-frame: immediate return to the reset state. Lock is reacquired only after LOCK_FRAMES+1 frame boundaries.

Decomposition:
- Package vga_pkg holds the 640x480 timing constants (H/V totals, sync, porch, active) shared with vga_ctrl, plus the RGB width localparam (12).
- One natural sub-module: vga_sync_edge, a per-signal history register with polarity-aware LE output. It is instantiated for hs and vs.

Test Plan:
- Reset with rstn=0 mid-stream -> all outputs 0 within the same cycle; after release with no hs, locked stays 0 and pix_x/pix_y stay 0.
- Nominal 800x525 stream from vga_ctrl, LOCK_FRAMES=2 -> locked rises 1 cycle after the third vcnt=0 boundary; h_len=800, v_len=525; then first de=1 with pix_x=0, pix_y=0 exactly 1 cycle after the sample at hcnt=144, vcnt=35; last de at pix_x=639, pix_y=479.
- Data alignment: color bar stream (F00 for x<60, FFF for x>580) -> rgb_out=F00 at pix_x=0..59 and =FFF at pix_x=581..639; rgb_out=0 whenever de=0.
- Corrupt one line to 799 samples while locked -> h_len=799 for that line; locked stays 1 until the next frame boundary, then drops; it re-locks after 2 clean frames.
- hs held inactive -> hcnt saturates; locked=0 one cycle after hcnt reaches 2047; de never asserts.
- vs LE coincident with hs LE, and vs LE mid-line -> in both cases vcnt=0 at the next/same hs LE and frame_start pulses once per frame.
